// File: rtl/control_next_state.sv
// rtl/control_next_state.sv - mARC next-state logic and memory-wait sequencer (optional ONEHOT_CHECK_EN).
module control_next_state #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        preset_n,
    input  logic [12:0] q,
    input  logic [31:0] ir,
    input  logic        mem_ack,
    input  logic        trap_clr,
    output logic [12:0] d,
    output logic        mem_req,
    output logic        mem_we,
    output logic        bus_err,
    output logic        illegal
`ifdef ONEHOT_CHECK_EN
    ,
    output logic        state_err
`endif
);

    localparam logic [12:0] ST_IF    = 13'h0001;
    localparam logic [12:0] ST_ID    = 13'h0002;
    localparam logic [12:0] ST_ALU   = 13'h0004;
    localparam logic [12:0] ST_LDA   = 13'h0008;
    localparam logic [12:0] ST_LDM   = 13'h0010;
    localparam logic [12:0] ST_STA   = 13'h0020;
    localparam logic [12:0] ST_STM   = 13'h0040;
    localparam logic [12:0] ST_BR    = 13'h0080;
    localparam logic [12:0] ST_CALL  = 13'h0100;
    localparam logic [12:0] ST_JMPL  = 13'h0200;
    localparam logic [12:0] ST_SETHI = 13'h0400;
    localparam logic [12:0] ST_WB    = 13'h0800;
    localparam logic [12:0] ST_TRAP  = 13'h1000;
    localparam logic [12:0] MEM_MASK = ST_IF | ST_LDM | ST_STM;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             valid;
    logic             in_mem;
    logic             timeout;
    logic             trap_exit;
    logic             id_bad;
    logic [12:0]      id_next;
    logic [12:0]      raw_next;
    logic [1:0]       op;
    logic [2:0]       op2;
    logic [5:0]       op3;

    assign op  = ir[31:30];
    assign op2 = ir[24:22];
    assign op3 = ir[24:19];

`ifdef ONEHOT_CHECK_EN
    assign valid = $onehot(q);
`else
    assign valid = 1'b1;
`endif

    assign in_mem    = valid && ((q & MEM_MASK) != 13'b0);
    assign timeout   = in_mem && !mem_ack && (wait_cnt == CNT_LAST);
    assign trap_exit = valid && q[12] && trap_clr;
    assign id_bad    = (id_next == ST_TRAP);

    always_comb begin
        id_next = ST_TRAP;
        case (op)
            2'b01: id_next = ST_CALL;
            2'b00: begin
                if (op2 == 3'b100)      id_next = ST_SETHI;
                else if (op2 == 3'b010) id_next = ST_BR;
            end
            2'b10: begin
                if (op3 == 6'b111000)   id_next = ST_JMPL;
                else if (!op3[5])       id_next = ST_ALU;
            end
            default: begin
                if (op3 == 6'b000000)      id_next = ST_LDA;
                else if (op3 == 6'b000100) id_next = ST_STA;
            end
        endcase
    end

    // Each set bit of q contributes its own successor; one-hot q gives one term.
    always_comb begin
        raw_next = 13'b0;
        if (q[0])  raw_next = raw_next | (mem_ack ? ST_ID : ST_IF);
        if (q[1])  raw_next = raw_next | id_next;
        if (q[2])  raw_next = raw_next | ST_WB;
        if (q[3])  raw_next = raw_next | ST_LDM;
        if (q[4])  raw_next = raw_next | (mem_ack ? ST_WB : ST_LDM);
        if (q[5])  raw_next = raw_next | ST_STM;
        if (q[6])  raw_next = raw_next | (mem_ack ? ST_IF : ST_STM);
        if (q[7])  raw_next = raw_next | ST_IF;
        if (q[8])  raw_next = raw_next | ST_IF;
        if (q[9])  raw_next = raw_next | ST_IF;
        if (q[10]) raw_next = raw_next | ST_WB;
        if (q[11]) raw_next = raw_next | ST_IF;
        if (q[12]) raw_next = raw_next | (trap_clr ? ST_IF : ST_TRAP);
    end

    always_comb begin
        d = raw_next;
        if (!preset_n || !valid) d = ST_IF;
        else if (timeout)        d = ST_TRAP;
    end

    assign mem_req = preset_n && in_mem;
    assign mem_we  = preset_n && valid && q[6];

    always_ff @(posedge clk) begin
        if (!preset_n) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            illegal  <= 1'b0;
`ifdef ONEHOT_CHECK_EN
            state_err <= 1'b0;
`endif
        end else begin
            if (in_mem && !mem_ack && !timeout) wait_cnt <= wait_cnt + 1'b1;
            else                                wait_cnt <= '0;
            bus_err <= timeout || (bus_err && !trap_exit);
            illegal <= (valid && q[1] && id_bad) || (illegal && !trap_exit);
`ifdef ONEHOT_CHECK_EN
            state_err <= state_err || !valid;
`endif
        end
    end

endmodule

// File: tb/tb_control_next_state.sv
// tb/tb_control_next_state.sv - directed and randomized check of control_next_state against a state-table model.
module tb_control_next_state;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        preset_n = 1'b0;
    logic [12:0] q = 13'h0001;
    logic [31:0] ir = 32'h0;
    logic        mem_ack = 1'b0;
    logic        trap_clr = 1'b0;
    logic [12:0] d;
    logic        mem_req, mem_we, bus_err, illegal;
`ifdef ONEHOT_CHECK_EN
    logic        state_err;
`endif

    control_next_state #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
        .clk(clk), .preset_n(preset_n), .q(q), .ir(ir), .mem_ack(mem_ack),
        .trap_clr(trap_clr), .d(d), .mem_req(mem_req), .mem_we(mem_we),
        .bus_err(bus_err), .illegal(illegal)
`ifdef ONEHOT_CHECK_EN
        , .state_err(state_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int          m_wait = 0;
    bit          m_bus = 0, m_ill = 0, m_serr = 0, flags_known = 0;
    logic [12:0] e_d;
    bit          e_req, e_we, e_timeout, e_valid;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Instruction class lookup straight from the op/op2/op3 tables.
    function automatic int decode(input logic [31:0] w);
        logic [1:0] o;
        logic [2:0] o2;
        logic [5:0] o3;
        o = w[31:30]; o2 = w[24:22]; o3 = w[24:19];
        if (o == 2'd1) return 8;
        if (o == 2'd0) return (o2 == 3'd4) ? 10 : (o2 == 3'd2) ? 7 : 12;
        if (o == 2'd2) return (o3 == 6'd56) ? 9 : (o3 < 6'd32) ? 2 : 12;
        return (o3 == 6'd0) ? 3 : (o3 == 6'd4) ? 5 : 12;
    endfunction

    function automatic int succ(input int s, input logic [31:0] w, input bit ack, input bit clr);
        case (s)
            0:  return ack ? 1 : 0;
            1:  return decode(w);
            2, 10: return 11;
            3:  return 4;
            4:  return ack ? 11 : 4;
            5:  return 6;
            6:  return ack ? 0 : 6;
            12: return clr ? 0 : 12;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_mem(input int s);
        return (s == 0) || (s == 4) || (s == 6);
    endfunction

    task automatic model_comb();
        bit any_mem;
        any_mem = 0;
`ifdef ONEHOT_CHECK_EN
        e_valid = ($countones(q) == 1);
`else
        e_valid = 1;
`endif
        e_d = 13'h0;
        for (int i = 0; i < 13; i++)
            if (q[i]) begin
                e_d[succ(i, ir, mem_ack, trap_clr)] = 1'b1;
                if (is_mem(i)) any_mem = 1;
            end
        any_mem   = any_mem && e_valid;
        e_timeout = preset_n && any_mem && !mem_ack && (m_wait == T - 1);
        e_req     = preset_n && any_mem;
        e_we      = preset_n && e_valid && q[6];
        if (!preset_n || !e_valid) e_d = 13'h0001;
        else if (e_timeout)        e_d = 13'h1000;
    endtask

    task automatic model_seq();
        if (!preset_n) begin
            m_wait = 0; m_bus = 0; m_ill = 0; m_serr = 0; flags_known = 1;
        end else begin
            bit leave;
            leave  = e_valid && q[12] && trap_clr;
            m_wait = (e_req && !mem_ack && !e_timeout) ? m_wait + 1 : 0;
            if (leave) begin m_bus = 0; m_ill = 0; end
            if (e_timeout) m_bus = 1;
            if (e_valid && q[1] && decode(ir) == 12) m_ill = 1;
            if (!e_valid) m_serr = 1;
        end
    endtask

    task automatic step(input logic [12:0] qi, input logic [31:0] iri, input bit ack, input bit clr, input bit rst);
        @(negedge clk);
        q = qi; ir = iri; mem_ack = ack; trap_clr = clr; preset_n = rst;
        #1;
        model_comb();
        check_val("d", d, e_d);
        check_val("mem_req", mem_req, e_req);
        check_val("mem_we", mem_we, e_we);
        if (flags_known) begin
            check_val("bus_err", bus_err, m_bus);
            check_val("illegal", illegal, m_ill);
`ifdef ONEHOT_CHECK_EN
            check_val("state_err", state_err, m_serr);
`endif
        end
        @(posedge clk);
        model_seq();
    endtask

    logic [31:0] ir_tab [0:9] = '{32'hC0000000, 32'hC0200000, 32'hC1F80000, 32'h80000000,
                                  32'h81C00000, 32'h84000000, 32'h01000000, 32'h00800000,
                                  32'h40000000, 32'h00000000};

    initial begin
        logic [12:0] nq;
        logic [31:0] w;

        // reset with TRAP on q, then TRAP holds until trap_clr
        step(13'h1000, 32'h0, 0, 0, 0);
        step(13'h1000, 32'h0, 0, 0, 0);
        check_val("rst_d", d, 13'h0001);
        check_val("rst_bus", bus_err, 0);
        check_val("rst_ill", illegal, 0);
        step(13'h1000, 32'h0, 0, 0, 1);
        check_val("trap_hold", d, 13'h1000);
        step(13'h1000, 32'h0, 0, 1, 1);
        check_val("trap_clr", d, 13'h0001);

        // load path: IF waits 3 cycles, then ack
        w = 32'hC0000000;
        nq = 13'h0001;
        for (int i = 0; i < 3; i++) step(nq, w, 0, 0, 1);
        step(nq, w, 1, 0, 1); check_val("ld_if", d, 13'h0002); nq = e_d;
        step(nq, w, 0, 0, 1); check_val("ld_id", d, 13'h0008); nq = e_d;
        step(nq, w, 0, 0, 1); nq = e_d;
        step(nq, w, 1, 0, 1); check_val("ld_ldm", d, 13'h0800); nq = e_d;
        step(nq, w, 0, 0, 1); check_val("ld_wb", d, 13'h0001);

        // store timeout
        w = 32'hC0200000;
        step(13'h0002, w, 0, 0, 1); nq = e_d;
        step(nq, w, 0, 0, 1); nq = e_d;
        for (int i = 0; i < T; i++) begin
            step(nq, w, 0, 0, 1);
            check_val("st_we", mem_we, 1);
            nq = e_d;
        end
        check_val("st_to_d", nq, 13'h1000);
        step(nq, w, 0, 0, 1); check_val("st_bus", bus_err, 1);
        step(13'h1000, w, 0, 1, 1);
        step(13'h0001, w, 0, 0, 1); check_val("st_bus_clr", bus_err, 0);

        // ack in the timeout cycle wins
        for (int i = 0; i < T - 2; i++) step(13'h0001, w, 0, 0, 1);
        step(13'h0001, w, 1, 0, 1); check_val("bnd_d", d, 13'h0002);
        step(13'h0002, 32'h40000000, 0, 0, 1); check_val("bnd_bus", bus_err, 0);

        // illegal opcode, ALU and SETHI paths
        step(13'h0002, 32'hC1F80000, 0, 0, 1); check_val("ill_d", d, 13'h1000);
        step(13'h1000, 32'h0, 0, 0, 1); check_val("ill_flag", illegal, 1);
        step(13'h1000, 32'h0, 0, 1, 1);
        step(13'h0002, 32'h80000000, 0, 0, 1); check_val("alu_d", d, 13'h0004);
        step(13'h0004, 32'h0, 0, 0, 1); check_val("alu_wb", d, 13'h0800);
        step(13'h0002, 32'h01000000, 0, 0, 1); check_val("sethi_d", d, 13'h0400);
        step(13'h0400, 32'h0, 0, 0, 1); check_val("sethi_wb", d, 13'h0800);

`ifdef ONEHOT_CHECK_EN
        step(13'h0006, 32'h0, 0, 0, 1); check_val("oh_d", d, 13'h0001);
        step(13'h0001, 32'h0, 0, 0, 1); check_val("oh_err", state_err, 1);
        step(13'h0001, 32'h0, 0, 0, 0);
        step(13'h0001, 32'h0, 0, 0, 1); check_val("oh_rst", state_err, 0);
`endif

        // randomized run: q mostly follows the model, with jumps and resets
        nq = 13'h0001;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6)       nq = 13'(1) << $urandom_range(0, 12);
            else if (r < 9)  nq = 13'($urandom);
            w = ($urandom_range(0, 3) == 0) ? $urandom : ir_tab[$urandom_range(0, 9)];
            step(nq, w, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 199) != 0);
            nq = e_d;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
